// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary output layer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bnn_pkg;

  // Controller states: gather bits, score once, then hold the result for downstream.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    HOLD    = 2'd3
  } bnn_state_t;

  // Default vector width, and the matching reset threshold (half the bits agree).
  localparam int BNN_N_IN_DEF   = 8;
  localparam int BNN_THRESH_DEF = BNN_N_IN_DEF / 2;

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int bnn_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// XNOR of activation and weight vectors, followed by a popcount of agreeing bits.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module bnn_xnor_popcount #(
  parameter int N_IN = 8,
  parameter int CW   = 4
) (
  input  logic [N_IN-1:0] i_act,
  input  logic [N_IN-1:0] i_wt,
  output logic [CW-1:0]   o_score
);

  logic [N_IN-1:0] w_match;

  assign w_match = ~(i_act ^ i_wt);

  // Count positions where activation and weight agree.
  always_comb begin
    o_score = '0;
    for (int i = 0; i < N_IN; i++) begin
      o_score = o_score + CW'(w_match[i]);
    end
  end

endmodule

// File: rtl/bnn_output_layer.sv
// Serial-to-parallel activation collector plus XNOR-popcount threshold classifier.
// Latency: 2 cycles from last accepted bit to out_valid; N_IN+2 cycles min per vector.
// Backpressure: result held until out_ready; in_ready low while evaluating/holding.
// Optional feature: define BNN_SCORE_OUT_EN to expose the registered score on out_score.
module bnn_output_layer
  import bnn_pkg::*;
#(
  parameter  int N_IN   = BNN_N_IN_DEF,
  parameter  int THRESH = N_IN / 2,
  localparam int CW     = bnn_cw(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_bit,
  output logic            in_ready,
  input  logic            wt_load,
  input  logic [N_IN-1:0] wt_data,
  input  logic            thr_load,
  input  logic [CW-1:0]   thr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_class,
`ifdef BNN_SCORE_OUT_EN
  output logic [CW-1:0]   out_score,
`endif
  output logic            busy
);

  bnn_state_t      r_state;
  bnn_state_t      w_next;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_act;
  logic [N_IN-1:0] r_wt;
  logic [CW-1:0]   r_thr;
  logic            r_class;
  logic [CW-1:0]   w_score;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_release;

`ifdef BNN_SCORE_OUT_EN
  logic [CW-1:0]   r_score;
`endif

  bnn_xnor_popcount #(
    .N_IN (N_IN),
    .CW   (CW)
  ) u_popcount (
    .i_act   (r_act),
    .i_wt    (r_wt),
    .o_score (w_score)
  );

  assign w_accept  = in_valid & w_in_ready;
  assign w_release = w_out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode; handshake outputs depend on state only.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = COLLECT;
      end
      COLLECT: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_cnt == CW'(N_IN - 1))) w_next = EVAL;
      end
      EVAL: begin
        w_next = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Shift accepted bits into their arrival slot; wipe the vector once the result is taken.
  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_cnt <= '0;
      r_act <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        if (r_cnt == CW'(i)) r_act[i] <= in_bit;
      end
    end
  end

  // Programmable weight and threshold; loads are accepted in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wt  <= '1;
      r_thr <= CW'(THRESH);
    end else begin
      if (wt_load)  r_wt  <= wt_data;
      if (thr_load) r_thr <= thr_data;
    end
  end

  // Capture the classification in the single EVAL cycle so it stays frozen through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_class <= 1'b0;
    end else if (r_state == EVAL) begin
      r_class <= (w_score >= r_thr);
    end
  end

`ifdef BNN_SCORE_OUT_EN
  // Registered score alongside the class bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_score <= '0;
    end else if (r_state == EVAL) begin
      r_score <= w_score;
    end
  end

  assign out_score = r_score;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_class = r_class;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/bnn_output_layer.md
# bnn_output_layer

Downstream consumer of the first-layer BNN neuron. It collects the neuron's serial 1-bit activations into an `N_IN`-bit vector, then computes the XNOR-popcount of that vector against a stored weight vector. The score is compared with a programmable threshold, and the block emits a registered class bit over a valid/ready handshake. It turns the single neuron output pin into a complete two-layer binary classifier.

## Interface
- `N_IN`, default 8: activation bits per vector (2..32).
- `THRESH`, default `N_IN/2`: reset value of the threshold register.
- `CW`, localparam `$clog2(N_IN+1)`: score/threshold width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  activation bit valid.
- `in_bit`  in  1  activation bit (neuron `o_neuron`).
- `in_ready`  out  1  block accepts a bit this cycle.
- `wt_load`  in  1  load `wt_data` into weight register.
- `wt_data`  in  `N_IN`  weight vector.
- `thr_load`  in  1  load `thr_data` into threshold register.
- `thr_data`  in  `CW`  threshold.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `out_class`  out  1  1 when score >= threshold.
- `out_score`  out  `CW`  popcount score (only with `BNN_SCORE_OUT_EN`).
- `busy`  out  1  state is not IDLE.

## Operation
- The state machine has four states: IDLE, COLLECT, EVAL and HOLD.
- **IDLE** (count = 0):
  - `in_ready` = 1.
  - An accepted bit (`in_valid & in_ready`) is written to `act[0]`, count becomes 1, and the state goes to COLLECT.
- **COLLECT**:
  - `in_ready` = 1.
  - Each accepted bit k (arrival order, 0-based) is written to `act[k]`, and count increments.
  - On acceptance of bit `N_IN-1` the state goes to EVAL.
  - Cycles with `in_valid` low are gaps; they do not change state.
- **EVAL** (exactly one cycle):
  - `in_ready` = 0.
  - score = popcount(~(act ^ weight)); class = (score >= threshold), unsigned.
  - score and class are registered; the state goes to HOLD.
- **HOLD**:
  - `out_valid` = 1 and `in_ready` = 0.
  - `out_class` and `out_score` are stable.
  - `in_valid` is ignored.
  - On `out_valid & out_ready` the state goes to IDLE, with count and `act` cleared.
- **Weight and threshold loads**:
  - `wt_load` and `thr_load` are honoured in every state.
  - The register updates at the clock edge.
  - EVAL uses the value held during the EVAL cycle. A load coincident with EVAL therefore affects only the next vector.
- **Threshold range**: a threshold above `N_IN` makes class always 0. A threshold of 0 makes class always 1.
- **Reset values**:
  - State IDLE, count 0, `act` 0.
  - Weight all-ones, so score equals popcount(act).
  - Threshold = `THRESH`.
  - Outputs: `in_ready` 1, `out_valid` 0, `out_class` 0, `out_score` 0, `busy` 0.
- **Reset mid-operation**: a partial vector or pending result is discarded. Programmed weight and threshold also revert to their reset values.

## Timing
- With the last bit accepted at edge t, EVAL occupies cycle t+1, and `out_valid` is high from cycle t+2.
- Bit-to-result latency is 2 cycles.
- The handshake edge (`out_valid & out_ready`) returns the state to IDLE, so `in_ready` is 1 in the following cycle. There is no skid buffer.
- Minimum period per vector is `N_IN`+2 cycles.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only; they have no combinational path from inputs.

## Configuration
- `BNN_SCORE_OUT_EN` defined: the `out_score` port exists, holding the registered score. It is 0 at reset and held stable during HOLD.
- `BNN_SCORE_OUT_EN` undefined: the `out_score` port is absent. Only the class bit is registered, and behaviour is otherwise identical.

## Structure
- Package `bnn_pkg` holds:
  - the state enum (IDLE, COLLECT, EVAL, HOLD);
  - the `CW` width helper function;
  - the default-threshold localparam.
- Sub-module `bnn_xnor_popcount`: purely combinational XNOR plus popcount, with `N_IN`-bit inputs and a `CW`-bit score. It is instantiated once.

## Test plan
All scenarios use `N_IN`=8 and `THRESH`=4.

1. **Reset defaults**: after reset, feed bits 1,1,1,1,0,0,0,0 → act=8'h0F, score 4, `out_class`=1, `out_valid` rising 2 cycles after the last bit.
2. **Weight load**: `wt_load` 8'hF0, then the same bits → score 0, `out_class`=0.
3. **Threshold load**: `thr_load` 8 with weight 8'hFF:
   - bits for act=8'hFF → score 8, class 1;
   - bits for act=8'hFE → score 7, class 0.
4. **Backpressure**: `out_ready` held low 10 cycles → `out_valid`, class and score stable, `in_ready`=0, `in_valid` pulses ignored. `out_ready` high → `in_ready`=1 the next cycle.
5. **Gaps and mid-vector reset**:
   - Random `in_valid` gaps inside a vector → same result as the gap-free run.
   - `rst` after 5 bits → count 0, weight 8'hFF, threshold 4; the next 8 bits form a fresh vector.
6. **Load during EVAL**: `wt_load` 8'h00 in the EVAL cycle → the current result uses the old weight, and the next vector uses 8'h00.
